// File: rtl/europa_lpddr_perf_cnt_sampler.sv
// Ctrl-domain controller/reader for a bank of LPDDR async perf counters: drives enable/flush,
// samples wrap-safe deltas every window into saturating totals. Optional IRQ: EUROPA_LPDDR_PERF_SAMPLER_IRQ_EN.
module europa_lpddr_perf_cnt_sampler #(
    parameter int NumCounters  = 4,
    parameter int CounterWidth = 32,
    parameter int AccWidth     = 48,
    parameter int WindowWidth  = 24,
    parameter int SettleCycles = 8
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_start,
    input  logic                                i_stop,
    input  logic [WindowWidth-1:0]              i_window_cycles,
    input  logic [NumCounters*CounterWidth-1:0] i_cnt_value,
`ifdef EUROPA_LPDDR_PERF_SAMPLER_IRQ_EN
    input  logic                                i_irq_clr,
    output logic                                o_irq,
`endif
    output logic                                o_cnt_en,
    output logic                                o_cnt_flush,
    output logic [NumCounters*AccWidth-1:0]     o_acc,
    output logic [NumCounters-1:0]              o_acc_sat,
    output logic                                o_sample_valid,
    output logic                                o_busy
);

    localparam int SettleW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam logic [SettleW-1:0] SettleInit = SettleW'(SettleCycles - 1);
    localparam int PadW = AccWidth - CounterWidth + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } state_e;

    state_e                  state_r, next_s;
    logic [SettleW-1:0]      settle_r;
    logic [WindowWidth-1:0]  timer_r, window_r;
    logic [CounterWidth-1:0] prev_r [NumCounters];
    logic [AccWidth-1:0]     acc_r [NumCounters];
    logic [NumCounters-1:0]  acc_sat_r;
    logic                    cnt_en_r, cnt_flush_r, sample_valid_r, busy_r;

    logic [CounterWidth-1:0] delta_s [NumCounters];
    logic [AccWidth:0]       sum_s [NumCounters];
    logic [AccWidth-1:0]     acc_next_s [NumCounters];
    logic [NumCounters-1:0]  sat_hit_s;
    logic                    start_s, baseline_s, sample_s;

    assign start_s    = (state_r == ST_IDLE) && i_start && !i_stop;
    assign baseline_s = (state_r == ST_SETTLE) && !i_stop && (settle_r == {SettleW{1'b0}});
    assign sample_s   = (state_r == ST_RUN) && (i_stop || (timer_r == {WindowWidth{1'b0}}));

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode; stop always returns to IDLE, even when it coincides with start
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) next_s = ST_FLUSH;
                else         next_s = ST_IDLE;
            end
            ST_FLUSH: begin
                if (i_stop) next_s = ST_IDLE;
                else        next_s = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (i_stop)          next_s = ST_IDLE;
                else if (baseline_s) next_s = ST_RUN;
                else                 next_s = ST_SETTLE;
            end
            ST_RUN: begin
                if (i_stop) next_s = ST_IDLE;
                else        next_s = ST_RUN;
            end
            default: next_s = ST_IDLE;
        endcase
    end

    // Per-counter modular delta and saturating add (single adder stage)
    always_comb begin
        for (int i = 0; i < NumCounters; i++) begin
            delta_s[i] = i_cnt_value[i*CounterWidth +: CounterWidth] - prev_r[i];
            sum_s[i]   = {1'b0, acc_r[i]} + {{PadW{1'b0}}, delta_s[i]};
            if (sum_s[i][AccWidth]) begin
                acc_next_s[i] = {AccWidth{1'b1}};
                sat_hit_s[i]  = 1'b1;
            end else begin
                acc_next_s[i] = sum_s[i][AccWidth-1:0];
                sat_hit_s[i]  = 1'b0;
            end
        end
    end

    // Window latch, settle countdown and window timer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            window_r <= {WindowWidth{1'b0}};
            settle_r <= {SettleW{1'b0}};
            timer_r  <= {WindowWidth{1'b0}};
        end else begin
            if (start_s) begin
                window_r <= (i_window_cycles == {WindowWidth{1'b0}}) ? WindowWidth'(1) : i_window_cycles;
            end
            if (state_r == ST_FLUSH) begin
                settle_r <= SettleInit;
            end else if ((state_r == ST_SETTLE) && (settle_r != {SettleW{1'b0}})) begin
                settle_r <= settle_r - SettleW'(1);
            end
            if (baseline_s || sample_s) begin
                timer_r <= window_r - WindowWidth'(1);
            end else if (state_r == ST_RUN) begin
                timer_r <= timer_r - WindowWidth'(1);
            end
        end
    end

    // Baselines, accumulators and sticky saturation flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NumCounters; i++) begin
                prev_r[i] <= {CounterWidth{1'b0}};
                acc_r[i]  <= {AccWidth{1'b0}};
            end
            acc_sat_r <= {NumCounters{1'b0}};
        end else begin
            for (int i = 0; i < NumCounters; i++) begin
                if (start_s) begin
                    acc_r[i] <= {AccWidth{1'b0}};
                end else if (sample_s) begin
                    acc_r[i] <= acc_next_s[i];
                end
                if (baseline_s || sample_s) begin
                    prev_r[i] <= i_cnt_value[i*CounterWidth +: CounterWidth];
                end
            end
            if (start_s) begin
                acc_sat_r <= {NumCounters{1'b0}};
            end else if (sample_s) begin
                acc_sat_r <= acc_sat_r | sat_hit_s;
            end
        end
    end

    // Registered control outputs, derived from the state being entered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_en_r       <= 1'b0;
            cnt_flush_r    <= 1'b0;
            sample_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            cnt_en_r       <= (next_s != ST_IDLE);
            cnt_flush_r    <= (next_s == ST_FLUSH);
            sample_valid_r <= sample_s;
            busy_r         <= (next_s != ST_IDLE);
        end
    end

    // Flatten accumulators onto the output bus
    always_comb begin
        o_acc = {(NumCounters*AccWidth){1'b0}};
        for (int i = 0; i < NumCounters; i++) begin
            o_acc[i*AccWidth +: AccWidth] = acc_r[i];
        end
    end

    assign o_acc_sat      = acc_sat_r;
    assign o_cnt_en       = cnt_en_r;
    assign o_cnt_flush    = cnt_flush_r;
    assign o_sample_valid = sample_valid_r;
    assign o_busy         = busy_r;

`ifdef EUROPA_LPDDR_PERF_SAMPLER_IRQ_EN
    logic irq_r;

    // Interrupt flag; a saturation bit can only rise on a sample, so the sample covers both set causes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_r <= 1'b0;
        end else if (sample_s) begin
            irq_r <= 1'b1;
        end else if (i_irq_clr) begin
            irq_r <= 1'b0;
        end
    end

    assign o_irq = irq_r;
`endif

endmodule
